// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with a built-in TX FIFO.
// Frames go out LSB first at CLKS_PER_BIT clocks per bit. The frame format
// is start, DATA_BITS data, optional parity, then STOP_BITS stop bits.
// Optional feature macro UART_TX_BREAK_EN adds the i_Break input. That input
// holds the line low between frames and enforces a mark-after-break gap.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Enable,
`ifdef UART_TX_BREAK_EN
  input  logic                          i_Break,
`endif
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Overflow,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CLK_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_BITS - 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic                 full, empty, push, pop;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx, stop_last, bit_end;
  logic [DATA_BITS-1:0] shift;
  logic                 par;
  logic                 can_start, brk_line;

  // Ready is judged before any pop this cycle, so a full FIFO rejects the push.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign push         = i_Tx_DV && !full;
  assign o_Tx_Ready   = !full;
  assign o_Fifo_Count = count;

  assign bit_end   = (clk_cnt == CLK_MAX);
  assign stop_last = (STOP_BITS == 1) || stop_idx;

  assign o_Tx_Active = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);
  assign o_Tx_Done   = (state == CLEANUP);

`ifdef UART_TX_BREAK_EN
  localparam int MW = $clog2(2*CLKS_PER_BIT);
  localparam logic [MW-1:0] MAB_MAX = MW'(2*CLKS_PER_BIT - 1);

  logic          mab_pend;
  logic [MW-1:0] mab_cnt;

  // A break is only applied between frames and never cuts into a frame.
  assign brk_line  = i_Break && ((state == IDLE) || (state == CLEANUP));
  assign can_start = !i_Break && !mab_pend;

  // Mark-after-break timer. A break arms it, and it then counts released IDLE cycles.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      mab_pend <= 1'b0;
      mab_cnt  <= '0;
    end else if (brk_line) begin
      mab_pend <= 1'b1;
      mab_cnt  <= '0;
    end else if (mab_pend && (state == IDLE)) begin
      if (mab_cnt == MAB_MAX) begin
        mab_pend <= 1'b0;
        mab_cnt  <= '0;
      end else begin
        mab_cnt <= mab_cnt + 1'b1;
      end
    end
  end
`else
  assign brk_line  = 1'b0;
  assign can_start = 1'b1;
`endif

  // FIFO storage. Words need no reset because the occupancy count gates every read.
  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Tx_Byte;
  end

  // FIFO pointers, occupancy count and the overflow pulse.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Overflow <= 1'b0;
    end else begin
      o_Overflow <= i_Tx_DV && full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer. Dropping the enable abandons the current frame without a done pulse.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:    if (!empty && can_start) begin
                 pop       = 1'b1;
                 state_nxt = START;
               end
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && (bit_idx == BIT_MAX))
                 state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && stop_last) state_nxt = CLEANUP;
      CLEANUP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!i_Enable) begin
      state_nxt = IDLE;
      pop       = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Latch the head word and its parity bit when a frame is launched.
  always_ff @(posedge i_Clock) begin
    if (pop) begin
      shift <= mem[rd_ptr];
      par   <= (^mem[rd_ptr]) ^ (PARITY_MODE == 1);
    end
  end

  // Bit timing. The clock counter wraps at every bit boundary, and the indices step on each wrap.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || !i_Enable || (state == IDLE) || (state == CLEANUP)) begin
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (bit_end) begin
      clk_cnt <= '0;
      if (state == DATA) bit_idx <= (bit_idx == BIT_MAX) ? '0 : bit_idx + 1'b1;
      if (state == STOP) stop_idx <= !stop_idx;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  // Registered line driver. It lags the state by one clock.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || !i_Enable) begin
      o_Tx_Serial <= 1'b1;
    end else begin
      case (state)
        START:         o_Tx_Serial <= 1'b0;
        DATA:          o_Tx_Serial <= shift[bit_idx];
        PARITY:        o_Tx_Serial <= par;
        IDLE, CLEANUP: o_Tx_Serial <= !brk_line;
        default:       o_Tx_Serial <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg. It uses two instances:
//   dut_a: 8 data bits, even parity, 1 stop bit.
//   dut_b: 7 data bits, odd parity, 2 stop bits.
// Both instances run at 4 clocks per bit with a 4-entry FIFO.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_en = 1'b1, a_dv = 1'b0;
  logic [7:0] a_byte = '0;
  logic       a_rdy, a_ovf, a_act, a_ser, a_done;
  logic [2:0] a_cnt;
  logic       b_en = 1'b1, b_dv = 1'b0;
  logic [6:0] b_byte = '0;
  logic       b_rdy, b_ovf, b_act, b_ser, b_done;
  logic [2:0] b_cnt;
`ifdef UART_TX_BREAK_EN
  logic       a_brk = 1'b0, b_brk = 1'b0;
`endif

  int nerr = 0, nchk = 0;
  int act, dn, hi, lo, mx, ovf, j, r;
  logic [10:0] fr;
  logic [7:0]  w3 [6];
  logic [7:0]  rxw [5];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
                .FIFO_DEPTH(4)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Enable(a_en),
`ifdef UART_TX_BREAK_EN
    .i_Break(a_brk),
`endif
    .i_Tx_DV(a_dv), .i_Tx_Byte(a_byte), .o_Tx_Ready(a_rdy), .o_Fifo_Count(a_cnt),
    .o_Overflow(a_ovf), .o_Tx_Active(a_act), .o_Tx_Serial(a_ser), .o_Tx_Done(a_done));

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2),
                .FIFO_DEPTH(4)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Enable(b_en),
`ifdef UART_TX_BREAK_EN
    .i_Break(b_brk),
`endif
    .i_Tx_DV(b_dv), .i_Tx_Byte(b_byte), .o_Tx_Ready(b_rdy), .o_Fifo_Count(b_cnt),
    .o_Overflow(b_ovf), .o_Tx_Active(b_act), .o_Tx_Serial(b_ser), .o_Tx_Done(b_done));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- reset state
    tick; tick;
    chk("rst_cnt",  32'(a_cnt),  0);
    chk("rst_rdy",  32'(a_rdy),  1);
    chk("rst_ser",  32'(a_ser),  1);
    chk("rst_act",  32'(a_act),  0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_ovf",  32'(a_ovf),  0);
    chk("rst_b_ser", 32'(b_ser), 1);
    rst = 1'b0;
    tick;

    // ---- 1: 0xA5, even parity -> start, A5 LSB first, parity 0, stop
    fr = {1'b1, 1'b0, 8'hA5, 1'b0};
    a_dv = 1'b1; a_byte = 8'hA5; tick; a_dv = 1'b0;
    chk("t1_cnt_push", 32'(a_cnt), 1);
    act = 0; dn = 0;
    for (int t = 1; t <= 60; t++) begin
      tick;
      if (t == 1) chk("t1_ser_lag", 32'(a_ser), 1);
      if (a_act)  act++;
      if (a_done) dn++;
      if (t >= 4 && (t % 4) == 0 && t <= 44) chk($sformatf("t1_bit%0d", t/4 - 1), 32'(a_ser), 32'(fr[t/4 - 1]));
    end
    chk("t1_active", act, 44);
    chk("t1_done", dn, 1);

    // ---- 2: 0x07, 7 bits, odd parity, 2 stop bits
    fr = {1'b1, 1'b1, 1'b0, 7'h07, 1'b0};
    b_dv = 1'b1; b_byte = 7'h07; tick; b_dv = 1'b0;
    act = 0; dn = 0; hi = 0;
    for (int t = 1; t <= 60; t++) begin
      tick;
      if (b_act)  act++;
      if (b_done) dn++;
      if (t >= 38 && t <= 45 && b_ser) hi++;
      if (t >= 4 && (t % 4) == 0 && t <= 44) chk($sformatf("t2_bit%0d", t/4 - 1), 32'(b_ser), 32'(fr[t/4 - 1]));
    end
    chk("t2_stop_high", hi, 8);
    chk("t2_active", act, 44);
    chk("t2_done", dn, 1);

    // ---- 3: six back-to-back pushes into depth-4 FIFO
    w3[0] = 8'h11; w3[1] = 8'h22; w3[2] = 8'h33; w3[3] = 8'h44; w3[4] = 8'h55; w3[5] = 8'h66;
    mx = 0; ovf = 0; dn = 0; act = 0;
    for (int k = 0; k < 5; k++) rxw[k] = 8'h00;
    for (int t = 0; t <= 240; t++) begin
      if (t < 6) begin a_dv = 1'b1; a_byte = w3[t]; end else a_dv = 1'b0;
      tick;
      if (int'(a_cnt) > mx) mx = int'(a_cnt);
      if (a_ovf)  ovf++;
      if (a_done) dn++;
      if (a_act)  act++;
      if (t == 4) chk("t3_ready_full", 32'(a_rdy), 0);
      if (t >= 8) begin
        j = (t - 8) / 46;
        r = (t - 8) % 46;
        if (j < 5 && (r % 4) == 0 && r < 32) rxw[j][r/4] = a_ser;
      end
    end
    chk("t3_peak", mx, 4);
    chk("t3_overflow", ovf, 1);
    chk("t3_done", dn, 5);
    chk("t3_active", act, 220);
    for (int k = 0; k < 5; k++) chk($sformatf("t3_word%0d", k), 32'(rxw[k]), 32'(w3[k]));
    chk("t3_empty", 32'(a_cnt), 0);

    // ---- 4: drop enable mid-DATA with 2 words queued
    for (int t = 0; t <= 14; t++) begin
      if (t < 3) begin a_dv = 1'b1; a_byte = 8'h31 + 8'(t); end else a_dv = 1'b0;
      tick;
    end
    a_dv = 1'b0;
    a_en = 1'b0; tick;
    dn = 0;
    if (a_done) dn++;
    chk("t4_ser_idle", 32'(a_ser), 1);
    chk("t4_act_off", 32'(a_act), 0);
    chk("t4_kept", 32'(a_cnt), 2);
    a_dv = 1'b1; a_byte = 8'h3C; tick; a_dv = 1'b0;
    if (a_done) dn++;
    chk("t4_push_dis", 32'(a_cnt), 3);
    for (int t = 0; t < 10; t++) begin tick; if (a_done) dn++; end
    chk("t4_no_done", dn, 0);
    a_en = 1'b1; tick;
    chk("t4_pop", 32'(a_cnt), 2);
    chk("t4_restart", 32'(a_act), 1);
    tick;
    chk("t4_start_bit", 32'(a_ser), 0);
    dn = 0;
    for (int t = 0; t < 200; t++) begin tick; if (a_done) dn++; end
    chk("t4_done", dn, 3);
    chk("t4_empty", 32'(a_cnt), 0);

    // ---- 5: reset mid-PARITY with 3 words queued
    for (int t = 0; t <= 38; t++) begin
      if (t < 4) begin a_dv = 1'b1; a_byte = 8'h50 + 8'(t); end else a_dv = 1'b0;
      tick;
    end
    a_dv = 1'b0;
    chk("t5_queued", 32'(a_cnt), 3);
    rst = 1'b1; tick;
    chk("t5_cnt",  32'(a_cnt),  0);
    chk("t5_rdy",  32'(a_rdy),  1);
    chk("t5_ser",  32'(a_ser),  1);
    chk("t5_act",  32'(a_act),  0);
    chk("t5_done", 32'(a_done), 0);
    chk("t5_ovf",  32'(a_ovf),  0);
    rst = 1'b0;
    act = 0; lo = 0;
    for (int t = 0; t < 60; t++) begin
      tick;
      if (a_act)  act++;
      if (!a_ser) lo++;
    end
    chk("t5_silent_act", act, 0);
    chk("t5_silent_ser", lo, 0);

`ifdef UART_TX_BREAK_EN
    // ---- 6: break raised during STOP, released with a word queued
    dn = 0;
    a_dv = 1'b1; a_byte = 8'hC3; tick; a_dv = 1'b0;
    for (int t = 1; t <= 47; t++) begin
      if (t == 42) a_brk = 1'b1;
      tick;
      if (a_done) dn++;
      if (t == 44) chk("t6_stop_kept", 32'(a_ser), 1);
    end
    chk("t6_done", dn, 1);
    chk("t6_break_low", 32'(a_ser), 0);
    a_dv = 1'b1; a_byte = 8'h5A; tick; a_dv = 1'b0;
    for (int t = 0; t < 6; t++) tick;
    chk("t6_brk_act", 32'(a_act), 0);
    chk("t6_brk_ser", 32'(a_ser), 0);
    a_brk = 1'b0;
    hi = 0; lo = 0;
    for (int t = 0; t < 40; t++) begin
      tick;
      if (lo == 0) begin
        if (a_ser) hi++;
        else       lo = 1;
      end
    end
    chk("t6_started", lo, 1);
    chk("t6_mark_after_break", 32'(hi >= 8), 1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter that supersedes the fixed 8N1 transmitter.
- Configurable data width, parity mode and stop-bit count.
- Built-in transmit FIFO, so producers can queue words without waiting for each frame to finish.
- Sits between the SPI/UART configuration logic and the serial pin; emits LSB-first frames at CLKS_PER_BIT clocks per bit.

Parameters:
CLKS_PER_BIT, 5208, clocks per serial bit; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 0, parity selection: 0 none, 1 odd, 2 even.
STOP_BITS, 1, number of stop bits; 1 or 2.
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..64.

Ports:
i_Clock  input  1  system clock; all logic on posedge.
i_Reset  input  1  synchronous, active-high reset.
i_Enable  input  1  transmitter enable; low aborts any frame and holds the line idle.
i_Tx_DV  input  1  write strobe; the word is accepted when i_Tx_DV && o_Tx_Ready.
i_Tx_Byte  input  DATA_BITS  word to transmit.
o_Tx_Ready  input/output note: output  1  FIFO not full.
o_Fifo_Count  output  $clog2(FIFO_DEPTH)+1  number of words queued (0..FIFO_DEPTH).
o_Overflow  output  1  one-cycle pulse when i_Tx_DV is asserted while the FIFO is full.
o_Tx_Active  output  1  high from START through the last STOP bit.
o_Tx_Serial  output  1  registered serial line; idle level is high.
o_Tx_Done  output  1  one-cycle pulse in CLEANUP.

Behaviour:
Reset (i_Reset=1 at a clock edge):
- FIFO emptied; o_Fifo_Count=0, o_Tx_Ready=1.
- o_Overflow=0, o_Tx_Active=0, o_Tx_Serial=1, o_Tx_Done=0.
- State=IDLE; counters cleared.
- Reset has priority over every other input.

FIFO:
- Circular buffer with read/write pointers of width $clog2(FIFO_DEPTH) that wrap naturally, plus a separate count.
- Push when i_Tx_DV && !full. Push when full: word dropped, o_Overflow pulses, contents unchanged.
- Push and pop in the same cycle: both take effect and the count is unchanged.
- If full, the push is still rejected, because o_Tx_Ready is evaluated before the pop.

States: IDLE, START, DATA, PARITY, STOP, CLEANUP.
- IDLE: line high. If i_Enable && FIFO non-empty, pop the head into the shift register, compute parity, go to START.
- START: line 0 for CLKS_PER_BIT cycles, then DATA.
- DATA: line = shift[bit_idx] for CLKS_PER_BIT cycles per bit; bit_idx runs 0..DATA_BITS-1.
  - After the last bit: go to PARITY if PARITY_MODE!=0, else STOP.
- PARITY: line = XOR of the data bits, inverted for odd mode. Lasts CLKS_PER_BIT cycles, then STOP.
- STOP: line 1 for STOP_BITS*CLKS_PER_BIT cycles, then CLEANUP.
- CLEANUP: 1 cycle; line 1, o_Tx_Done=1, o_Tx_Active=0; then IDLE.

Clock counter:
- Counts 0..CLKS_PER_BIT-1 and clears on every bit boundary.
- Width is $clog2(CLKS_PER_BIT); never compared against out-of-width constants.

Latency:
- Push at edge N into an empty FIFO with the FSM in IDLE: state enters START at edge N+1, and o_Tx_Serial falls at edge N+2.
- Back-to-back words: exactly one IDLE cycle plus one CLEANUP cycle of high level between frames.
- Frame length: (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS)*CLKS_PER_BIT cycles, plus CLEANUP and IDLE.

i_Enable:
- i_Enable=0 at any edge: state goes to IDLE, line goes high, counters clear, no o_Tx_Done.
- The word in flight is discarded; queued FIFO words are retained.
- Pushes are still accepted while disabled.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input i_Break (1 bit).
  - While i_Break=1 in IDLE or CLEANUP, o_Tx_Serial is driven 0 and no new frame starts.
  - A frame already in progress completes first, then the break is applied.
  - On release, the line returns high for at least 2*CLKS_PER_BIT cycles (mark-after-break) before the next START.
  - o_Tx_Active stays 0 during a break.
- Undefined: the port does not exist and the line is never held low outside START/data/parity bits.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, PARITY_MODE=2, push 0xA5 -> line sampled mid-bit reads 0,1,0,1,0,0,1,0,1,0(parity),1(stop); o_Tx_Active high for 44 cycles; o_Tx_Done pulses once.
2. PARITY_MODE=1, DATA_BITS=7, STOP_BITS=2, push 0x07 -> parity bit 0; stop high for 8 cycles; frame active for 44 cycles.
3. FIFO_DEPTH=4: push 6 words in 6 consecutive cycles while idle -> the first word pops, the next 4 are accepted, o_Fifo_Count peaks at 4, and the 6th push raises o_Overflow for 1 cycle. All 5 accepted words are transmitted in order with 1 IDLE + 1 CLEANUP gap between frames.
4. Drop i_Enable mid-DATA with 2 words queued -> line high the next cycle, no o_Tx_Done; re-enable -> the next queued word starts and o_Fifo_Count decrements by 1.
5. Assert i_Reset mid-PARITY with 3 words queued -> at the next edge all outputs take their reset values and o_Fifo_Count=0; no further frames are sent.
6. Only with UART_TX_BREAK_EN: assert i_Break during STOP -> the frame completes and the line then goes 0. Release i_Break with a word queued -> the line is high for at least 8 cycles (CLKS_PER_BIT=4) before START.
